// File: rtl/counter_pkg.sv
// Shared encodings for the up/down/bounce counter.
//   MODE_*  : 2-bit count mode selector values
//   DIR_*   : direction flag values (1 = counting up)
package counter_pkg;

  localparam logic [1:0] MODE_UP   = 2'b00;  // count up, wrap hi -> lo
  localparam logic [1:0] MODE_DN   = 2'b01;  // count down, wrap lo -> hi
  localparam logic [1:0] MODE_BNC  = 2'b10;  // triangle between lo and hi
  localparam logic [1:0] MODE_HOLD = 2'b11;  // freeze

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/count_next_calc.sv
// Combinational step function for updown_bounce_counter.
// Given the current count/direction, mode and bounds, produces the value the
// counter takes on an enabled step.
//   count, dir, mode, lo, hi : current state and configuration
//   next_count, next_dir     : state after one enabled step
//   wrap_evt                 : step is a wrap (00/01) or a reversal (10)
//   out_of_range             : count lies outside [lo, hi]
// Assumes lo < hi whenever the result is used; the top level gates on cfg_err.
module count_next_calc
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] count,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] next_count,
  output logic             next_dir,
  output logic             wrap_evt,
  output logic             out_of_range
);

  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] count_dec;

  assign count_inc    = count + WIDTH'(1);
  assign count_dec    = count - WIDTH'(1);
  assign out_of_range = (count < lo) || (count > hi);

  always_comb begin
    next_count = count;
    next_dir   = dir;
    wrap_evt   = 1'b0;

    unique case (mode)
      MODE_UP: begin
        next_dir = DIR_UP;
        if (out_of_range) begin
          next_count = lo;
        end else if (count == hi) begin
          next_count = lo;
          wrap_evt   = 1'b1;
        end else begin
          next_count = count_inc;
        end
      end

      MODE_DN: begin
        next_dir = DIR_DN;
        if (out_of_range) begin
          next_count = hi;
        end else if (count == lo) begin
          next_count = hi;
          wrap_evt   = 1'b1;
        end else begin
          next_count = count_dec;
        end
      end

      MODE_BNC: begin
        if (out_of_range) begin
          // Restart the triangle from the bottom, heading up.
          next_count = lo;
          next_dir   = DIR_UP;
        end else if (dir == DIR_UP) begin
          if (count == hi) begin
            // Reverse without dwelling: hi is visited once per period.
            next_count = count_dec;
            next_dir   = DIR_DN;
            wrap_evt   = 1'b1;
          end else begin
            next_count = count_inc;
          end
        end else begin
          if (count == lo) begin
            next_count = count_inc;
            next_dir   = DIR_UP;
            wrap_evt   = 1'b1;
          end else begin
            next_count = count_dec;
          end
        end
      end

      MODE_HOLD: begin
        next_count = count;
        next_dir   = dir;
      end

      default: begin
        next_count = count;
        next_dir   = dir;
      end
    endcase
  end

endmodule

// File: rtl/updown_bounce_counter.sv
// Run-time bounded counter with up-wrap, down-wrap and bounce modes.
// Ports:
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset
//   en       : advance one step per cycle
//   mode     : 00 up-wrap, 01 down-wrap, 10 bounce, 11 hold
//   lo, hi   : inclusive bounds (lo < hi required to count)
//   load     : synchronous load of load_val, clamped into [lo, hi]
//   load_val : value to load
//   count    : registered count
//   dir      : registered direction, 1 = up
//   at_hi    : count == hi (combinational)
//   at_lo    : count == lo (combinational)
//   wrap     : registered one-cycle pulse on wrap or reversal
//   cfg_err  : lo >= hi (combinational); freezes the counter
// Priority on each edge: reset > cfg_err > load > en.
// WIDTH is expected in 2..16 and RST_VAL < 2**WIDTH.
module updown_bounce_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             at_hi,
  output logic             at_lo,
  output logic             wrap,
  output logic             cfg_err
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] step_count;
  logic             step_dir;
  logic             step_wrap;
  logic             step_oor;
  logic [WIDTH-1:0] load_clamped;

  count_next_calc #(
    .WIDTH(WIDTH)
  ) u_next (
    .count       (count_q),
    .dir         (dir_q),
    .mode        (mode),
    .lo          (lo),
    .hi          (hi),
    .next_count  (step_count),
    .next_dir    (step_dir),
    .wrap_evt    (step_wrap),
    .out_of_range(step_oor)
  );

  assign cfg_err = (lo >= hi);

  always_comb begin
    if (load_val < lo) begin
      load_clamped = lo;
    end else if (load_val > hi) begin
      load_clamped = hi;
    end else begin
      load_clamped = load_val;
    end
  end

  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    wrap_d  = 1'b0;

    if (cfg_err) begin
      // Bounds are unusable: freeze, ignoring load and en.
      count_d = count_q;
      dir_d   = dir_q;
    end else if (load) begin
      count_d = load_clamped;
    end else if (en && (mode != MODE_HOLD)) begin
      count_d = step_count;
      dir_d   = step_dir;
      // Recovery from an out-of-range count is never reported as a wrap.
      wrap_d  = step_wrap && !step_oor;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= WIDTH'(RST_VAL);
      dir_q   <= DIR_UP;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign dir   = dir_q;
  assign wrap  = wrap_q;
  assign at_hi = (count_q == hi);
  assign at_lo = (count_q == lo);

endmodule

// File: tb/tb_updown_bounce_counter.sv
module tb_updown_bounce_counter;

  localparam int unsigned W  = 4;
  localparam int unsigned RV = 0;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b1;
  logic [1:0]   mode = 2'b10;
  logic [W-1:0] lo = '0;
  logic [W-1:0] hi = 4'd7;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] count;
  logic         dir, at_hi, at_lo, wrap, cfg_err;

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  int m_count = RV;
  int m_dir   = 1;
  int m_wrap  = 0;

  updown_bounce_counter #(
    .WIDTH  (W),
    .RST_VAL(RV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
    .lo      (lo),
    .hi      (hi),
    .load    (load),
    .load_val(load_val),
    .count   (count),
    .dir     (dir),
    .at_hi   (at_hi),
    .at_lo   (at_lo),
    .wrap    (wrap),
    .cfg_err (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: wrap modes as modular arithmetic over the span,
  // bounce as a signed step that reflects at the endpoints.
  always @(posedge clk or negedge rst) begin
    int l, h, span, step;
    l = int'(lo);
    h = int'(hi);
    if (!rst) begin
      m_count = RV;
      m_dir   = 1;
      m_wrap  = 0;
    end else begin
      m_wrap = 0;
      if (l >= h) begin
        // frozen
      end else if (load) begin
        m_count = (int'(load_val) < l) ? l : (int'(load_val) > h) ? h : int'(load_val);
      end else if (en && mode != 2'b11) begin
        span = h - l + 1;
        if (m_count < l || m_count > h) begin
          m_count = (mode == 2'b01) ? h : l;
          m_dir   = (mode == 2'b01) ? 0 : 1;
        end else if (mode == 2'b00) begin
          m_dir   = 1;
          m_wrap  = (m_count == h);
          m_count = (m_count - l + 1) % span + l;
        end else if (mode == 2'b01) begin
          m_dir   = 0;
          m_wrap  = (m_count == l);
          m_count = (m_count - l - 1 + span) % span + l;
        end else begin
          if ((m_dir == 1 && m_count == h) || (m_dir == 0 && m_count == l)) begin
            m_dir  = 1 - m_dir;
            m_wrap = 1;
          end
          step    = (m_dir == 1) ? 1 : -1;
          m_count = m_count + step;
        end
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    chk("count", int'(count), m_count);
    chk("dir", int'(dir), m_dir);
    chk("wrap", int'(wrap), m_wrap);
    chk("at_hi", int'(at_hi), int'(m_count == int'(hi)));
    chk("at_lo", int'(at_lo), int'(m_count == int'(lo)));
    chk("cfg_err", int'(cfg_err), int'(int'(lo) >= int'(hi)));
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic lit(input string name, input int c, input int d, input int w);
    chk({name, ".count"}, int'(count), c);
    chk({name, ".dir"}, int'(dir), d);
    chk({name, ".wrap"}, int'(wrap), w);
  endtask

  initial begin
    #1 rst = 1'b0;
    #2 lit("reset", 0, 1, 0);
    #9 rst = 1'b1;                         // t = 12

    // Bounce 0..7..0..1 with lo=0 hi=7
    for (int i = 1; i <= 7; i++) begin
      cyc();
      lit("bnc_up", i, 1, 0);
    end
    cyc(); lit("bnc_rev_hi", 6, 0, 1);
    for (int i = 5; i >= 0; i--) begin
      cyc();
      lit("bnc_dn", i, 0, 0);
    end
    cyc(); lit("bnc_rev_lo", 1, 1, 1);
    cyc(); lit("bnc_2", 2, 1, 0);

    // Up-wrap lo=2 hi=5 from count 2
    mode = 2'b00; lo = 4'd2; hi = 4'd5;
    cyc(); lit("up3", 3, 1, 0);
    cyc(); lit("up4", 4, 1, 0);
    cyc(); lit("up5", 5, 1, 0);
    chk("up5.at_hi", int'(at_hi), 1);
    cyc(); lit("up_wrap", 2, 1, 1);
    chk("up_wrap.at_lo", int'(at_lo), 1);
    cyc(); lit("up3b", 3, 1, 0);

    // Down-wrap, load 4 first
    mode = 2'b01; load = 1'b1; load_val = 4'd4;
    cyc(); lit("dn_load", 4, 1, 0);
    load = 1'b0;
    cyc(); lit("dn3", 3, 0, 0);
    cyc(); lit("dn2", 2, 0, 0);
    cyc(); lit("dn_wrap", 5, 0, 1);
    cyc(); lit("dn4", 4, 0, 0);

    // Clamp above hi
    load = 1'b1; load_val = 4'd9;
    cyc(); lit("clamp_hi", 5, 0, 0);
    // Clamp below lo
    load_val = 4'd0;
    cyc(); lit("clamp_lo", 2, 0, 0);

    // Bound violation: count 6, hi drops to 4, mode up
    mode = 2'b00; lo = 4'd0; hi = 4'd7; load_val = 4'd6;
    cyc(); lit("load6", 6, 0, 0);
    load = 1'b0; hi = 4'd4;
    cyc(); lit("recover", 0, 1, 0);
    cyc(); lit("recover+1", 1, 1, 0);
    lo = 4'd3; hi = 4'd3;
    #1 chk("cfg_err_now", int'(cfg_err), 1);
    cyc(); lit("cfg_frz", 1, 1, 0);
    load = 1'b1; load_val = 4'd2;
    cyc(); lit("cfg_load_ign", 1, 1, 0);
    load = 1'b0; lo = 4'd0; hi = 4'd7;

    // Async reset mid-bounce at count 5, dir 0
    mode = 2'b10; load = 1'b1; load_val = 4'd7;
    cyc(); lit("ld7", 7, 1, 0);
    load = 1'b0;
    cyc(); lit("rev7", 6, 0, 1);
    cyc(); lit("at5", 5, 0, 0);
    rst = 1'b0;
    #1 lit("async_rst", 0, 1, 0);
    #1 rst = 1'b1;
    cyc(); lit("post_rst", 1, 1, 0);

    // Simultaneous load and en in bounce at count 7
    load = 1'b1; load_val = 4'd7;
    cyc(); lit("ld7b", 7, 1, 0);
    load_val = 4'd3;
    cyc(); lit("load_beats_en", 3, 1, 0);
    load = 1'b0; mode = 2'b11;
    for (int i = 0; i < 5; i++) begin
      cyc();
      lit("hold_mode", 3, 1, 0);
    end
    mode = 2'b10; en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      lit("hold_en", 3, 1, 0);
    end
    en = 1'b1;
    cyc(); lit("resume", 4, 1, 0);

    @(posedge clk);
    #6;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
